// File: rtl/wt_mem_chan_arbiter_pkg.sv
// Shared helpers for the write-through memory channel arbiter.
// Holds index-width and round-robin wrap functions used by the top and the tag table.
package wt_mem_chan_arbiter_pkg;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/wt_mem_chan_arbiter_if.sv
// Memory adapter port of the channel arbiter: request handshake plus the tagged return beat.
interface wt_mem_chan_arbiter_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned RtrnWidth = 128,
    parameter int unsigned TagWidth  = 3
);
    logic                 req;
    logic                 ack;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [TagWidth-1:0]  tag;
    logic                 rtrn_vld;
    logic [TagWidth-1:0]  rtrn_tag;
    logic [RtrnWidth-1:0] rtrn_data;

    modport master (
        output req, we, addr, wdata, tag,
        input  ack, rtrn_vld, rtrn_tag, rtrn_data
    );

    modport slave (
        input  req, we, addr, wdata, tag,
        output ack, rtrn_vld, rtrn_tag, rtrn_data
    );
endinterface

// File: rtl/wt_mem_chan_arbiter_tag_table.sv
// Global tag table: per-tag {valid, chan, txid}, lowest-free-tag encoder and in-use counter.
module wt_mem_chan_arbiter_tag_table
    import wt_mem_chan_arbiter_pkg::*;
#(
    parameter int unsigned NumEntries = 8,
    parameter int unsigned ChanWidth  = 1,
    parameter int unsigned TxIdWidth  = 2,
    localparam int unsigned TagWidth  = idx_width(NumEntries)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_i,
    input  logic [TagWidth-1:0]  alloc_tag_i,
    input  logic [ChanWidth-1:0] alloc_chan_i,
    input  logic [TxIdWidth-1:0] alloc_txid_i,
    output logic                 free_vld_o,
    output logic [TagWidth-1:0]  free_tag_o,
    input  logic                 lookup_i,
    input  logic [TagWidth-1:0]  lookup_tag_i,
    output logic                 hit_o,
    output logic [ChanWidth-1:0] hit_chan_o,
    output logic [TxIdWidth-1:0] hit_txid_o,
    output logic [TagWidth:0]    outstanding_o
);

    typedef struct packed {
        logic                 valid;
        logic [ChanWidth-1:0] chan;
        logic [TxIdWidth-1:0] txid;
    } tag_entry_t;

    tag_entry_t        tbl_q [NumEntries];
    tag_entry_t        tbl_d [NumEntries];
    logic [TagWidth:0] cnt_q, cnt_d;
    logic              found;

    // The tag being allocated this cycle is not yet valid but is no longer free.
    always_comb begin
        found      = 1'b0;
        free_tag_o = '0;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            if (!found && !tbl_q[i].valid && !(alloc_i && alloc_tag_i == TagWidth'(i))) begin
                found      = 1'b1;
                free_tag_o = TagWidth'(i);
            end
        end
        free_vld_o = found;
    end

    always_comb begin
        hit_o      = 1'b0;
        hit_chan_o = '0;
        hit_txid_o = '0;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            if (lookup_i && lookup_tag_i == TagWidth'(i) && tbl_q[i].valid) begin
                hit_o      = 1'b1;
                hit_chan_o = tbl_q[i].chan;
                hit_txid_o = tbl_q[i].txid;
            end
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            if (hit_o && lookup_tag_i == TagWidth'(i)) begin
                tbl_d[i].valid = 1'b0;
            end
            if (alloc_i && alloc_tag_i == TagWidth'(i)) begin
                tbl_d[i] = '{valid: 1'b1, chan: alloc_chan_i, txid: alloc_txid_i};
            end
        end
    end

    always_comb begin
        unique case ({alloc_i, hit_o})
            2'b10:   cnt_d = cnt_q + (TagWidth + 1)'(1);
            2'b01:   cnt_d = cnt_q - (TagWidth + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < NumEntries; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            tbl_q <= tbl_d;
        end
    end

    assign outstanding_o = cnt_q;

endmodule

// File: rtl/wt_mem_chan_arbiter.sv
// N-channel round-robin memory arbiter: tags accepted requests globally and routes each
// tagged return back to its originating channel with the channel's txid restored.
module wt_mem_chan_arbiter
    import wt_mem_chan_arbiter_pkg::*;
#(
    parameter int unsigned NumChan        = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned TxIdWidth      = 2,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned TagWidth      = idx_width(MaxOutstanding)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumChan-1:0]             chan_req_i,
    output logic [NumChan-1:0]             chan_ack_o,
    input  logic [NumChan-1:0]             chan_we_i,
    input  logic [NumChan*AddrWidth-1:0]   chan_addr_i,
    input  logic [NumChan*DataWidth-1:0]   chan_wdata_i,
    input  logic [NumChan*TxIdWidth-1:0]   chan_txid_i,
    wt_mem_chan_arbiter_if.master          mem,
    output logic [NumChan-1:0]             chan_rtrn_vld_o,
    output logic [TxIdWidth-1:0]           chan_rtrn_txid_o,
    output logic [RtrnWidth-1:0]           chan_rtrn_data_o,
    output logic [TagWidth:0]              outstanding_o,
    output logic                           err_o
);

    localparam int unsigned ChanW = idx_width(NumChan);

    logic [AddrWidth-1:0] addr_arr  [NumChan];
    logic [DataWidth-1:0] wdata_arr [NumChan];
    logic [TxIdWidth-1:0] txid_arr  [NumChan];

    logic                 req_q, req_d;
    logic [ChanW-1:0]     grant_q, grant_d;
    logic [ChanW-1:0]     rr_q, rr_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [TxIdWidth-1:0] txid_q, txid_d;

    logic [NumChan-1:0]   rtrn_vld_q, rtrn_vld_d;
    logic [TxIdWidth-1:0] rtrn_txid_q, rtrn_txid_d;
    logic [RtrnWidth-1:0] rtrn_data_q, rtrn_data_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 free_vld;
    logic [TagWidth-1:0]  free_tag;
    logic                 hit;
    logic [ChanW-1:0]     hit_chan;
    logic [TxIdWidth-1:0] hit_txid;

    logic [NumChan-1:0]   cand;
    logic [ChanW-1:0]     ptr;
    logic [ChanW-1:0]     idx;
    logic [ChanW-1:0]     pick;
    logic                 pick_vld;

    always_comb begin
        for (int unsigned c = 0; c < NumChan; c++) begin
            addr_arr[c]  = chan_addr_i[c*AddrWidth +: AddrWidth];
            wdata_arr[c] = chan_wdata_i[c*DataWidth +: DataWidth];
            txid_arr[c]  = chan_txid_i[c*TxIdWidth +: TxIdWidth];
        end
    end

    assign accept = req_q & mem.ack;

    wt_mem_chan_arbiter_tag_table #(
        .NumEntries (MaxOutstanding),
        .ChanWidth  (ChanW),
        .TxIdWidth  (TxIdWidth)
    ) u_tag_table (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alloc_i       (accept),
        .alloc_tag_i   (tag_q),
        .alloc_chan_i  (grant_q),
        .alloc_txid_i  (txid_q),
        .free_vld_o    (free_vld),
        .free_tag_o    (free_tag),
        .lookup_i      (mem.rtrn_vld),
        .lookup_tag_i  (mem.rtrn_tag),
        .hit_o         (hit),
        .hit_chan_o    (hit_chan),
        .hit_txid_o    (hit_txid),
        .outstanding_o (outstanding_o)
    );

    // On accept the winner's request is still high this cycle, so it is masked out and
    // the search starts just past it.
    always_comb begin
        rr_d     = rr_q;
        ptr      = rr_q;
        cand     = chan_req_i;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        if (accept) begin
            rr_d          = ChanW'(wrap_inc(32'(grant_q), NumChan));
            ptr           = rr_d;
            cand[grant_q] = 1'b0;
        end
        for (int unsigned i = 0; i < NumChan; i++) begin
            idx = ChanW'((32'(ptr) + i) % NumChan);
            if (!pick_vld && cand[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        req_d   = req_q;
        grant_d = grant_q;
        tag_d   = tag_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        txid_d  = txid_q;
        if (!req_q || accept) begin
            req_d = pick_vld && free_vld;
            if (pick_vld && free_vld) begin
                grant_d = pick;
                tag_d   = free_tag;
                we_d    = chan_we_i[pick];
                addr_d  = addr_arr[pick];
                wdata_d = wdata_arr[pick];
                txid_d  = txid_arr[pick];
            end
        end
    end

    always_comb begin
        rtrn_vld_d  = '0;
        rtrn_txid_d = rtrn_txid_q;
        rtrn_data_d = rtrn_data_q;
        err_d       = err_q;
        if (mem.rtrn_vld) begin
            if (hit) begin
                rtrn_vld_d[hit_chan] = 1'b1;
                rtrn_txid_d          = hit_txid;
                rtrn_data_d          = mem.rtrn_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q       <= 1'b0;
            grant_q     <= '0;
            rr_q        <= '0;
            tag_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            txid_q      <= '0;
            rtrn_vld_q  <= '0;
            rtrn_txid_q <= '0;
            rtrn_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            req_q       <= req_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            tag_q       <= tag_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            txid_q      <= txid_d;
            rtrn_vld_q  <= rtrn_vld_d;
            rtrn_txid_q <= rtrn_txid_d;
            rtrn_data_q <= rtrn_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        chan_ack_o = '0;
        if (accept) begin
            chan_ack_o[grant_q] = 1'b1;
        end
    end

    assign mem.req          = req_q;
    assign mem.we           = we_q;
    assign mem.addr         = addr_q;
    assign mem.wdata        = wdata_q;
    assign mem.tag          = tag_q;
    assign chan_rtrn_vld_o  = rtrn_vld_q;
    assign chan_rtrn_txid_o = rtrn_txid_q;
    assign chan_rtrn_data_o = rtrn_data_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_wt_mem_chan_arbiter.sv
// Randomized bench for wt_mem_chan_arbiter: a tag-set/round-robin reference model predicts
// every request, ack, return, occupancy count and error flag cycle by cycle.
module tb_wt_mem_chan_arbiter;

    localparam int unsigned NumChan        = 3;
    localparam int unsigned AddrWidth      = 64;
    localparam int unsigned DataWidth      = 64;
    localparam int unsigned RtrnWidth      = 128;
    localparam int unsigned TxIdWidth      = 2;
    localparam int unsigned MaxOutstanding = 8;
    localparam int unsigned TagWidth       = 3;
    localparam int          NumCycles      = 900;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NumChan-1:0]           chan_req, chan_ack, chan_we;
    logic [NumChan*AddrWidth-1:0] chan_addr;
    logic [NumChan*DataWidth-1:0] chan_wdata;
    logic [NumChan*TxIdWidth-1:0] chan_txid;
    logic [NumChan-1:0]           rtrn_vld;
    logic [TxIdWidth-1:0]         rtrn_txid;
    logic [RtrnWidth-1:0]         rtrn_data;
    logic [TagWidth:0]            outstanding;
    logic                         err;

    wt_mem_chan_arbiter_if #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .RtrnWidth (RtrnWidth),
        .TagWidth  (TagWidth)
    ) mem_if ();

    wt_mem_chan_arbiter #(
        .NumChan        (NumChan),
        .AddrWidth      (AddrWidth),
        .DataWidth      (DataWidth),
        .RtrnWidth      (RtrnWidth),
        .TxIdWidth      (TxIdWidth),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .chan_req_i       (chan_req),
        .chan_ack_o       (chan_ack),
        .chan_we_i        (chan_we),
        .chan_addr_i      (chan_addr),
        .chan_wdata_i     (chan_wdata),
        .chan_txid_i      (chan_txid),
        .mem              (mem_if),
        .chan_rtrn_vld_o  (rtrn_vld),
        .chan_rtrn_txid_o (rtrn_txid),
        .chan_rtrn_data_o (rtrn_data),
        .outstanding_o    (outstanding),
        .err_o            (err)
    );

    // Requester state, held until the model sees it accepted.
    logic                 c_req   [NumChan];
    logic                 c_we    [NumChan];
    logic [AddrWidth-1:0] c_addr  [NumChan];
    logic [DataWidth-1:0] c_wdata [NumChan];
    logic [TxIdWidth-1:0] c_txid  [NumChan];

    always_comb begin
        chan_req   = '0;
        chan_we    = '0;
        chan_addr  = '0;
        chan_wdata = '0;
        chan_txid  = '0;
        for (int c = 0; c < NumChan; c++) begin
            chan_req[c]                          = c_req[c];
            chan_we[c]                           = c_we[c];
            chan_addr[c*AddrWidth +: AddrWidth]  = c_addr[c];
            chan_wdata[c*DataWidth +: DataWidth] = c_wdata[c];
            chan_txid[c*TxIdWidth +: TxIdWidth]  = c_txid[c];
        end
    end

    // Reference model: set of tags in use, owner of each tag, last granted channel.
    bit                   m_busy [MaxOutstanding];
    int                   m_chan [MaxOutstanding];
    logic [TxIdWidth-1:0] m_txid [MaxOutstanding];
    int                   m_cnt;
    bit                   m_err;
    int                   m_last;
    bit [NumChan-1:0]     m_acked;
    bit                   e_req;
    int                   e_grant;
    int                   e_tag;
    logic [NumChan-1:0]   e_rvld;
    logic [TxIdWidth-1:0] e_rtxid;
    logic [RtrnWidth-1:0] e_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < MaxOutstanding; t++) m_busy[t] = 1'b0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_last  = NumChan - 1;
        m_acked = '0;
        e_req   = 1'b0;
        e_rvld  = '0;
    endtask

    task automatic drive(input int cyc);
        int req_pct, ack_pct, rtrn_pct, bad_pct;
        bit only0;
        int busy_n, free_n;
        int busy_l [MaxOutstanding];
        int free_l [MaxOutstanding];
        req_pct  = 70;
        ack_pct  = 70;
        rtrn_pct = 40;
        bad_pct  = 0;
        only0    = 1'b0;
        rst = (cyc < 4) || (cyc >= 600 && cyc < 602);
        if (cyc < 20) begin
            only0 = 1'b1; req_pct = 100; ack_pct = 100; rtrn_pct = 100;
        end else if (cyc < 60) begin
            req_pct = 100; ack_pct = 100; rtrn_pct = 0;
        end else if (cyc >= 300 && cyc < 320) begin
            bad_pct = 30;
        end else if (cyc >= 602 && cyc < 604) begin
            bad_pct = 100;
        end
        for (int c = 0; c < NumChan; c++) begin
            if (m_acked[c]) c_req[c] = 1'b0;
            if (!c_req[c] && !(only0 && c != 0) && $urandom_range(99) < req_pct) begin
                c_req[c]   = 1'b1;
                c_we[c]    = 1'($urandom_range(1));
                c_addr[c]  = only0 ? 64'h1000 : {$urandom, $urandom};
                c_wdata[c] = {$urandom, $urandom};
                c_txid[c]  = only0 ? 2'd2 : TxIdWidth'($urandom_range(3));
            end
        end
        mem_if.ack = ($urandom_range(99) < ack_pct);
        busy_n = 0;
        free_n = 0;
        for (int t = 0; t < MaxOutstanding; t++) begin
            if (m_busy[t]) begin busy_l[busy_n] = t; busy_n++; end
            else begin free_l[free_n] = t; free_n++; end
        end
        mem_if.rtrn_vld = 1'b0;
        mem_if.rtrn_tag = '0;
        if (free_n > 0 && $urandom_range(99) < bad_pct) begin
            mem_if.rtrn_vld = 1'b1;
            mem_if.rtrn_tag = TagWidth'(free_l[$urandom_range(free_n - 1)]);
        end else if (busy_n > 0 && $urandom_range(99) < rtrn_pct) begin
            mem_if.rtrn_vld = 1'b1;
            mem_if.rtrn_tag = TagWidth'(busy_l[$urandom_range(busy_n - 1)]);
        end
        mem_if.rtrn_data = only0 ? {4{32'hA5A5A5A5}} : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_cycle();
        bit                 acc, n_req, hit;
        logic [NumChan-1:0] exp_ack;
        int                 ntag, nch, start, c, rt;
        if (rst) begin
            check("rst_mem_req", mem_if.req, 0);
            check("rst_mem_tag", mem_if.tag, 0);
            check("rst_mem_addr", mem_if.addr, 0);
            check("rst_chan_ack", chan_ack, 0);
            check("rst_rtrn_vld", rtrn_vld, 0);
            check("rst_rtrn_txid", rtrn_txid, 0);
            check("rst_rtrn_data", rtrn_data, 0);
            check("rst_outstanding", outstanding, 0);
            check("rst_err", err, 0);
            model_reset();
            return;
        end
        check("mem_req", mem_if.req, e_req);
        if (e_req) begin
            check("mem_tag", mem_if.tag, e_tag);
            check("mem_addr", mem_if.addr, c_addr[e_grant]);
            check("mem_we", mem_if.we, c_we[e_grant]);
            check("mem_wdata", mem_if.wdata, c_wdata[e_grant]);
        end
        acc     = e_req && mem_if.ack;
        exp_ack = '0;
        if (acc) exp_ack[e_grant] = 1'b1;
        check("chan_ack", chan_ack, exp_ack);
        check("rtrn_vld", rtrn_vld, e_rvld);
        if (e_rvld != '0) begin
            check("rtrn_txid", rtrn_txid, e_rtxid);
            check("rtrn_data", rtrn_data, e_rdata);
        end
        check("outstanding", outstanding, m_cnt);
        check("err", err, m_err);

        // Effects of the coming clock edge.
        m_acked = '0;
        e_rvld  = '0;
        rt      = int'(mem_if.rtrn_tag);
        hit     = mem_if.rtrn_vld && m_busy[rt];
        if (mem_if.rtrn_vld) begin
            if (hit) begin
                e_rvld[m_chan[rt]] = 1'b1;
                e_rtxid            = m_txid[rt];
                e_rdata            = mem_if.rtrn_data;
            end else begin
                m_err = 1'b1;
            end
        end
        n_req = e_req;
        ntag  = -1;
        nch   = -1;
        if (!e_req || acc) begin
            for (int t = 0; t < MaxOutstanding; t++) begin
                if (ntag < 0 && !m_busy[t] && !(acc && t == e_tag)) ntag = t;
            end
            start = acc ? (e_grant + 1) % NumChan : (m_last + 1) % NumChan;
            for (int k = 0; k < NumChan; k++) begin
                c = (start + k) % NumChan;
                if (nch < 0 && c_req[c] && !(acc && c == e_grant)) nch = c;
            end
            n_req = (ntag >= 0) && (nch >= 0);
        end
        if (acc) begin
            m_busy[e_tag]    = 1'b1;
            m_chan[e_tag]    = e_grant;
            m_txid[e_tag]    = c_txid[e_grant];
            m_last           = e_grant;
            m_acked[e_grant] = 1'b1;
            m_cnt++;
        end
        if (hit) begin
            m_busy[rt] = 1'b0;
            m_cnt--;
        end
        if ((!e_req || acc) && n_req) begin
            e_grant = nch;
            e_tag   = ntag;
        end
        e_req = n_req;
    endtask

    initial begin
        rst              = 1'b1;
        mem_if.ack       = 1'b0;
        mem_if.rtrn_vld  = 1'b0;
        mem_if.rtrn_tag  = '0;
        mem_if.rtrn_data = '0;
        for (int c = 0; c < NumChan; c++) begin
            c_req[c]   = 1'b0;
            c_we[c]    = 1'b0;
            c_addr[c]  = '0;
            c_wdata[c] = '0;
            c_txid[c]  = '0;
        end
        e_grant = 0;
        e_tag   = 0;
        e_rtxid = '0;
        e_rdata = '0;
        model_reset();
        for (int cyc = 0; cyc < NumCycles; cyc++) begin
            @(posedge clk);
            #1;
            drive(cyc);
            @(negedge clk);
            check_cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
